// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the byte-serial memory arbiter: state encodings,
// mem_len codes, IO window select and stall request values.
package mem_arbiter_pkg;

  localparam int unsigned ADDR_W_DEF = 32;
  localparam logic [1:0]  IO_SEL_DEF = 2'b11;

  localparam logic [1:0] LEN_BYTE = 2'b00;
  localparam logic [1:0] LEN_HALF = 2'b01;
  localparam logic [1:0] LEN_WORD = 2'b11;

  localparam logic STOP    = 1'b1;
  localparam logic NO_STOP = 1'b0;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_IF_RD  = 3'd1,
    ST_MEM_RD = 3'd2,
    ST_MEM_WR = 3'd3,
    ST_DONE   = 3'd4
  } state_e;

  // Byte count of an access; the unused code 2'b10 behaves as a word.
  function automatic logic [2:0] len_bytes(input logic [1:0] len);
    case (len)
      LEN_BYTE: return 3'd1;
      LEN_HALF: return 3'd2;
      LEN_WORD: return 3'd4;
      default:  return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Byte-serial memory controller: arbitrates IF fetches against MEM loads/stores
// (MEM wins) and serialises them onto the 8-bit RAM/IO bus.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter logic [1:0]  IO_SEL = IO_SEL_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_done,
  output logic [31:0]       if_inst,
  output logic              if_stall,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [1:0]        mem_len,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_wdata,
  output logic              mem_done,
  output logic [31:0]       mem_rdata,
  output logic              mem_stall,
  input  logic              io_buffer_full,
  input  logic [7:0]        ram_din,
  output logic [7:0]        ram_dout,
  output logic [ADDR_W-1:0] ram_a,
  output logic              ram_wr
);

  state_e            state_q;
  logic [2:0]        cnt_q;
  logic [2:0]        len_q;
  logic [ADDR_W-1:0] base_q;
  logic [31:0]       wdata_q;
  logic              io_q;
  logic [ADDR_W-1:0] ram_a_q;
  logic [7:0]        ram_dout_q;
  logic              ram_wr_q;
  logic [31:0]       if_inst_q;
  logic [31:0]       mem_rdata_q;
  logic              if_done_q;
  logic              mem_done_q;

  logic [1:0] rd_lane;
  logic [1:0] wr_lane;
  logic       idle_io;

  assign rd_lane = 2'(cnt_q - 3'd1);
  assign wr_lane = 2'(cnt_q + 3'd1);
  assign idle_io = (mem_addr[17:16] == IO_SEL);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 3'd0;
      len_q       <= 3'd0;
      base_q      <= '0;
      wdata_q     <= 32'd0;
      io_q        <= 1'b0;
      ram_a_q     <= '0;
      ram_dout_q  <= 8'd0;
      ram_wr_q    <= 1'b0;
      if_inst_q   <= 32'd0;
      mem_rdata_q <= 32'd0;
      if_done_q   <= 1'b0;
      mem_done_q  <= 1'b0;
    end else if (rdy) begin
      if_done_q  <= 1'b0;
      mem_done_q <= 1'b0;
      ram_wr_q   <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (mem_req) begin
            base_q  <= mem_addr;
            ram_a_q <= mem_addr;
            cnt_q   <= 3'd0;
            len_q   <= len_bytes(mem_len);
            wdata_q <= mem_wdata;
            io_q    <= idle_io;
            if (mem_we) begin
              ram_dout_q <= mem_wdata[7:0];
              ram_wr_q   <= ~(idle_io & io_buffer_full);
              state_q    <= ST_MEM_WR;
            end else begin
              mem_rdata_q <= 32'd0;
              state_q     <= ST_MEM_RD;
            end
          end else if (if_req) begin
            base_q  <= if_addr;
            ram_a_q <= if_addr;
            cnt_q   <= 3'd0;
            len_q   <= 3'd4;
            io_q    <= 1'b0;
            state_q <= ST_IF_RD;
          end
        end
        // cnt counts presented addresses; byte cnt-1 arrives on ram_din now.
        ST_IF_RD, ST_MEM_RD: begin
          if (cnt_q != 3'd0) begin
            if (state_q == ST_IF_RD) if_inst_q[{rd_lane, 3'b000} +: 8] <= ram_din;
            else                     mem_rdata_q[{rd_lane, 3'b000} +: 8] <= ram_din;
          end
          if (cnt_q == len_q) begin
            state_q <= ST_DONE;
            if (state_q == ST_IF_RD) if_done_q <= 1'b1;
            else                     mem_done_q <= 1'b1;
          end else begin
            if ((cnt_q + 3'd1) < len_q) ram_a_q <= base_q + ADDR_W'(cnt_q + 3'd1);
            cnt_q <= cnt_q + 3'd1;
          end
        end
        // A byte only counts as written once ram_wr was actually high for it.
        ST_MEM_WR: begin
          if (ram_wr_q) begin
            if ((cnt_q + 3'd1) == len_q) begin
              state_q    <= ST_DONE;
              mem_done_q <= 1'b1;
            end else begin
              ram_a_q    <= base_q + ADDR_W'(cnt_q + 3'd1);
              ram_dout_q <= wdata_q[{wr_lane, 3'b000} +: 8];
              ram_wr_q   <= ~(io_q & io_buffer_full);
              cnt_q      <= cnt_q + 3'd1;
            end
          end else begin
            ram_wr_q <= ~(io_q & io_buffer_full);
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign ram_a     = ram_a_q;
  assign ram_dout  = ram_dout_q;
  assign ram_wr    = ram_wr_q & rdy;
  assign if_inst   = if_inst_q;
  assign mem_rdata = mem_rdata_q;
  assign if_done   = if_done_q;
  assign mem_done  = mem_done_q;

  assign if_stall  = (if_req  && !if_done_q)  ? STOP : NO_STOP;
  assign mem_stall = (mem_req && !mem_done_q) ? STOP : NO_STOP;

endmodule
